// File: rtl/nav_cmd_sequencer.sv
// Host command sequencer: queues 16-bit nav commands in a DEPTH-entry FIFO, runs one at a time, acks on completion.
// strt_* and responses are registered one cycle after pop/completion; a push into a full FIFO (with no pop) is dropped and sets sticky ovfl.
module nav_cmd_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cmd,
  input  logic        cmd_rdy,
  input  logic        cal_done,
  input  logic        mv_cmplt,
  input  logic        sol_cmplt,
  output logic        strt_cal,
  output logic        in_cal,
  output logic        strt_hdng,
  output logic        strt_mv,
  output logic        stp_lft,
  output logic        stp_rght,
  output logic [11:0] dsrd_hdng,
  output logic        cmd_md,
  output logic        send_resp,
  output logic [7:0]  resp,
  output logic        ovfl
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [2:0] OP_CAL   = 3'b000;
  localparam logic [2:0] OP_HDNG  = 3'b001;
  localparam logic [2:0] OP_MOVE  = 3'b010;
  localparam logic [2:0] OP_SOLVE = 3'b011;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_ILL = 8'hEE;

  typedef enum logic [2:0] {IDLE, CAL, HDNG, MOVE, SOLVE} state_t;
  state_t state;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic [15:0]   head;
  logic [2:0]    head_op;
  logic          unused_head_bit;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = (state == IDLE) && !empty;
  // A pop frees the slot on the same edge, so a full FIFO can still accept.
  assign push    = cmd_rdy && (!full || pop);
  assign head    = mem[rd_ptr];
  assign head_op = head[15:13];
  assign unused_head_bit = head[12];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovfl   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if (cmd_rdy && !push) ovfl <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      strt_cal  <= 1'b0;
      in_cal    <= 1'b0;
      strt_hdng <= 1'b0;
      strt_mv   <= 1'b0;
      stp_lft   <= 1'b0;
      stp_rght  <= 1'b0;
      dsrd_hdng <= 12'h000;
      cmd_md    <= 1'b1;
      send_resp <= 1'b0;
      resp      <= 8'h00;
    end else begin
      strt_cal  <= 1'b0;
      strt_hdng <= 1'b0;
      strt_mv   <= 1'b0;
      send_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            case (head_op)
              OP_CAL: begin
                state    <= CAL;
                strt_cal <= 1'b1;
                in_cal   <= 1'b1;
              end
              OP_HDNG: begin
                state     <= HDNG;
                strt_hdng <= 1'b1;
                dsrd_hdng <= head[11:0];
              end
              OP_MOVE: begin
                state    <= MOVE;
                strt_mv  <= 1'b1;
                stp_lft  <= head[1];
                stp_rght <= head[0];
              end
              OP_SOLVE: begin
                state  <= SOLVE;
                cmd_md <= 1'b0;
              end
              default: begin
                send_resp <= 1'b1;
                resp      <= RESP_ILL;
              end
            endcase
          end
        end
        CAL: begin
          if (cal_done) begin
            state     <= IDLE;
            in_cal    <= 1'b0;
            send_resp <= 1'b1;
            resp      <= RESP_ACK;
          end
        end
        HDNG, MOVE: begin
          if (mv_cmplt) begin
            state     <= IDLE;
            send_resp <= 1'b1;
            resp      <= RESP_ACK;
          end
        end
        SOLVE: begin
          if (sol_cmplt) begin
            state     <= IDLE;
            cmd_md    <= 1'b1;
            send_resp <= 1'b1;
            resp      <= RESP_ACK;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nav_cmd_sequencer.sv
// Bench for nav_cmd_sequencer: queue-based reference model checked every cycle, plus directed literal scenarios and random traffic.
module tb_nav_cmd_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        cmd_rdy = 1'b0;
  logic        cal_done = 1'b0;
  logic        mv_cmplt = 1'b0;
  logic        sol_cmplt = 1'b0;
  logic        strt_cal, in_cal, strt_hdng, strt_mv, stp_lft, stp_rght;
  logic [11:0] dsrd_hdng;
  logic        cmd_md, send_resp, ovfl;
  logic [7:0]  resp;

  int checks = 0;
  int failures = 0;

  nav_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .cal_done(cal_done), .mv_cmplt(mv_cmplt), .sol_cmplt(sol_cmplt),
    .strt_cal(strt_cal), .in_cal(in_cal), .strt_hdng(strt_hdng), .strt_mv(strt_mv),
    .stp_lft(stp_lft), .stp_rght(stp_rght), .dsrd_hdng(dsrd_hdng), .cmd_md(cmd_md),
    .send_resp(send_resp), .resp(resp), .ovfl(ovfl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pending commands in a queue, plus the opcode of the
  // one command in flight (-1 when nothing is executing).
  logic [15:0] mq[$];
  int          busy_op = -1;
  logic [15:0] c;
  bit          popped, done;
  logic        e_strt_cal = 0, e_strt_hdng = 0, e_strt_mv = 0, e_send = 0;
  logic        e_stpl = 0, e_stpr = 0, e_ovfl = 0;
  logic [11:0] e_dsrd = 0;
  logic [7:0]  e_resp = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      busy_op = -1;
      e_strt_cal = 0; e_strt_hdng = 0; e_strt_mv = 0; e_send = 0;
      e_stpl = 0; e_stpr = 0; e_ovfl = 0; e_dsrd = 0; e_resp = 0;
    end else begin
      e_strt_cal = 0; e_strt_hdng = 0; e_strt_mv = 0; e_send = 0;
      popped = (busy_op < 0) && (mq.size() > 0);
      case (busy_op)
        0:       done = cal_done;
        1, 2:    done = mv_cmplt;
        3:       done = sol_cmplt;
        default: done = 0;
      endcase
      if (done) begin
        busy_op = -1;
        e_send = 1;
        e_resp = 8'hA5;
      end
      if (popped) c = mq.pop_front();
      if (cmd_rdy) begin
        if (mq.size() < DEPTH) mq.push_back(cmd);
        else e_ovfl = 1;
      end
      if (popped) begin
        case (c[15:13])
          3'd0: begin busy_op = 0; e_strt_cal = 1; end
          3'd1: begin busy_op = 1; e_strt_hdng = 1; e_dsrd = c[11:0]; end
          3'd2: begin busy_op = 2; e_strt_mv = 1; e_stpl = c[1]; e_stpr = c[0]; end
          3'd3: busy_op = 3;
          default: begin e_send = 1; e_resp = 8'hEE; end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("strt_cal", strt_cal, e_strt_cal);
    chk("strt_hdng", strt_hdng, e_strt_hdng);
    chk("strt_mv", strt_mv, e_strt_mv);
    chk("in_cal", in_cal, busy_op == 0);
    chk("cmd_md", cmd_md, busy_op != 3);
    chk("stp_lft", stp_lft, e_stpl);
    chk("stp_rght", stp_rght, e_stpr);
    chk("dsrd_hdng", dsrd_hdng, e_dsrd);
    chk("send_resp", send_resp, e_send);
    chk("resp", resp, e_resp);
    chk("ovfl", ovfl, e_ovfl);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_cmd(input logic [15:0] c_in);
    cmd = c_in;
    cmd_rdy = 1'b1;
    tick();
    cmd_rdy = 1'b0;
  endtask

  task automatic pulse(input int which);
    cal_done  = (which == 0);
    mv_cmplt  = (which == 1);
    sol_cmplt = (which == 2);
    tick();
    cal_done = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
  endtask

  logic [11:0] q_hdng [4] = '{12'h111, 12'h222, 12'h333, 12'h444};

  initial begin
    tick();
    tick();
    chk("lit_rst_cmd_md", cmd_md, 1'b1);
    chk("lit_rst_resp", resp, 8'h00);
    chk("lit_rst_ovfl", ovfl, 1'b0);
    chk("lit_rst_dsrd", dsrd_hdng, 12'h000);
    rst_n = 1'b1;
    tick();

    // heading
    drive_cmd(16'h23FF);
    tick();
    chk("lit_hdng_strt", strt_hdng, 1'b1);
    chk("lit_hdng_val", dsrd_hdng, 12'h3FF);
    tick();
    chk("lit_hdng_strt_low", strt_hdng, 1'b0);
    pulse(1);
    chk("lit_hdng_send", send_resp, 1'b1);
    chk("lit_hdng_resp", resp, 8'hA5);
    tick();
    chk("lit_hdng_send_low", send_resp, 1'b0);

    // move, with stray completions ignored
    drive_cmd(16'h4002);
    tick();
    chk("lit_mv_strt", strt_mv, 1'b1);
    chk("lit_mv_stpl", stp_lft, 1'b1);
    chk("lit_mv_stpr", stp_rght, 1'b0);
    pulse(0);
    chk("lit_mv_cal_ign", send_resp, 1'b0);
    pulse(2);
    chk("lit_mv_sol_ign", send_resp, 1'b0);
    pulse(1);
    chk("lit_mv_ack", send_resp, 1'b1);
    chk("lit_dsrd_held", dsrd_hdng, 12'h3FF);

    // queueing / overflow
    drive_cmd(16'h2001);
    tick();
    for (int i = 0; i < 5; i++) begin
      cmd = 16'h2000 + 16'(i + 1) * 16'h0111;
      cmd_rdy = 1'b1;
      tick();
    end
    cmd_rdy = 1'b0;
    chk("lit_q_ovfl", ovfl, 1'b1);
    for (int k = 0; k < 4; k++) begin
      pulse(1);
      chk("lit_q_ack", send_resp, 1'b1);
      tick();
      chk("lit_q_strt", strt_hdng, 1'b1);
      chk("lit_q_order", dsrd_hdng, q_hdng[k]);
    end
    pulse(1);
    tick();
    chk("lit_q_dropped", strt_hdng, 1'b0);

    // solve
    drive_cmd(16'h6000);
    tick();
    chk("lit_sol_md", cmd_md, 1'b0);
    pulse(1);
    chk("lit_sol_mv_ign", send_resp, 1'b0);
    chk("lit_sol_md_hold", cmd_md, 1'b0);
    pulse(2);
    chk("lit_sol_ack", resp, 8'hA5);
    chk("lit_sol_md_back", cmd_md, 1'b1);

    // calibrate
    drive_cmd(16'h0000);
    tick();
    chk("lit_cal_strt", strt_cal, 1'b1);
    chk("lit_cal_in", in_cal, 1'b1);
    tick();
    chk("lit_cal_in_hold", in_cal, 1'b1);
    pulse(0);
    chk("lit_cal_in_low", in_cal, 1'b0);
    chk("lit_cal_ack", send_resp, 1'b1);

    // illegal opcode
    drive_cmd(16'hE000);
    tick();
    chk("lit_ill_send", send_resp, 1'b1);
    chk("lit_ill_resp", resp, 8'hEE);
    chk("lit_ill_no_strt", {strt_cal, strt_hdng, strt_mv}, 3'b000);

    // reset while a heading is executing with another queued
    drive_cmd(16'h2123);
    tick();
    drive_cmd(16'h2456);
    rst_n = 1'b0;
    #1;
    chk("lit_rst_ovfl_clr", ovfl, 1'b0);
    chk("lit_rst_dsrd_clr", dsrd_hdng, 12'h000);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("lit_rst_fifo_empty", strt_hdng, 1'b0);
    pulse(1);
    chk("lit_rst_no_resp", send_resp, 1'b0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      rst_n     = ($urandom_range(0, 399) != 0);
      cmd_rdy   = ($urandom_range(0, 2) == 0);
      cmd       = 16'($urandom);
      cal_done  = ($urandom_range(0, 5) == 0);
      mv_cmplt  = ($urandom_range(0, 5) == 0);
      sol_cmplt = ($urandom_range(0, 5) == 0);
      tick();
    end
    rst_n = 1'b1;
    cmd_rdy = 1'b0; cal_done = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nav_cmd_sequencer.md
NAV_CMD_SEQUENCER -- requirements
Module: nav_cmd_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth in entries; power of 2, at least 2.
REQ-002 clk  input  1  50MHz system clock; all state on posedge clk.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 cmd  input  16  host command word: [15:13] opcode, [11:0] heading, [1] stop-left, [0] stop-right.
REQ-005 cmd_rdy  input  1  one-cycle pulse; push cmd into FIFO.
REQ-006 cal_done  input  1  one-cycle pulse from gyro calibration logic.
REQ-007 mv_cmplt  input  1  one-cycle pulse from navigation when a heading or forward move finishes.
REQ-008 sol_cmplt  input  1  one-cycle pulse from maze solver when the maze is solved.
REQ-009 strt_cal  output  1  one-cycle pulse; start gyro calibration.
REQ-010 in_cal  output  1  high while calibration is in progress.
REQ-011 strt_hdng  output  1  one-cycle pulse; start a new heading.
REQ-012 strt_mv  output  1  one-cycle pulse; start a forward move.
REQ-013 stp_lft, stp_rght  output  1 each  stop-at-opening qualifiers for the current move.
REQ-014 dsrd_hdng  output  12  desired heading for the heading PID.
REQ-015 cmd_md  output  1  1 = host command mode; 0 = solver owns navigation.
REQ-016 send_resp  output  1  one-cycle pulse; transmit resp to host.
REQ-017 resp  output  8  response byte: 8'hA5 = ack, 8'hEE = illegal opcode.
REQ-018 ovfl  output  1  sticky flag; a command was dropped because the FIFO was full.

Function
REQ-019 Opcodes: 3'b000 calibrate, 3'b001 heading, 3'b010 move, 3'b011 solve; any other opcode is illegal.
REQ-020 FIFO: on cmd_rdy, push when not full, or when full and a pop occurs in the same cycle.
REQ-021 FIFO full, cmd_rdy high, no pop: drop cmd, set ovfl, leave FIFO contents unchanged.
REQ-022 Read and write pointers wrap modulo DEPTH; occupancy counter is clog2(DEPTH)+1 bits.
REQ-023 FSM states: IDLE, CAL, HDNG, MOVE, SOLVE.
REQ-024 IDLE with FIFO non-empty: pop the head entry and decode it; the next state is set by the opcode.
REQ-025 A push into an empty FIFO is poppable no earlier than the following cycle.
REQ-026 strt_cal, strt_hdng and strt_mv are registered outputs, high exactly one cycle, in the cycle after the pop.
REQ-027 Heading pop: load dsrd_hdng <= cmd[11:0] on the same edge that raises strt_hdng; go to HDNG.
REQ-028 Move pop: load stp_lft <= cmd[1] and stp_rght <= cmd[0] on the same edge that raises strt_mv; go to MOVE.
REQ-029 stp_lft, stp_rght and dsrd_hdng hold their values until the next command of the same type loads them.
REQ-030 Calibrate pop: raise strt_cal and go to CAL; in_cal is high for every cycle in CAL.
REQ-031 Solve pop: go to SOLVE; cmd_md is 0 for every cycle in SOLVE and 1 in all other states.
REQ-032 Completion events: cal_done in CAL, mv_cmplt in HDNG or MOVE, sol_cmplt in SOLVE.
REQ-033 On the matching completion event: go to IDLE, and send_resp is high for one cycle after that edge with resp=8'hA5.
REQ-034 Completion pulses outside their matching state are ignored, with no response.
REQ-035 Illegal opcode pop: stay in IDLE, send_resp high next cycle with resp=8'hEE, no strt_* pulse.
REQ-036 Earliest next pop is the cycle after re-entering IDLE, so at most one command is in flight.
REQ-037 Queued commands are never popped while not in IDLE.
REQ-038 resp holds its last value between send_resp pulses.

Reset
REQ-039 rst_n low, at any time including mid-command: state=IDLE, FIFO empty, pointers 0, ovfl=0.
REQ-040 Output reset values: all strt_* and send_resp 0, in_cal=0, cmd_md=1, stp_lft=stp_rght=0, dsrd_hdng=12'h000, resp=8'h00.
REQ-041 Reset during an operation sends no response; the lost command is not replayed.

Verification
REQ-042 Heading: push 16'h23FF, wait, pulse mv_cmplt -> strt_hdng 1 cycle with dsrd_hdng=12'h3FF; send_resp 1 cycle after mv_cmplt, resp=8'hA5.
REQ-043 Move: push 16'h4002 -> strt_mv with stp_lft=1, stp_rght=0; a cal_done or sol_cmplt pulse during MOVE -> no response; mv_cmplt -> ack.
REQ-044 Queueing: push 5 heading commands back-to-back with DEPTH=4 while busy -> ovfl=1, 5th dropped; the 4 queued commands execute in order, one per mv_cmplt.
REQ-045 Solve: push 16'h6000 -> cmd_md=0 until sol_cmplt -> cmd_md=1 and resp=8'hA5; calibrate (16'h0000) -> in_cal high until cal_done.
REQ-046 Illegal: push 16'hE000 -> resp=8'hEE, no strt_* pulse; reset asserted in HDNG -> IDLE, FIFO empty, no response.
